// File: rtl/sm_pkg.sv
// sm_pkg: shared definitions for the shared-memory arbiter slice.
//   - Default geometry of the core array and the shared-memory macro.
//   - FSM state encoding and the latched operation type.
package sm_pkg;

    localparam int unsigned SM_ADDR_W = 12;
    localparam int unsigned SM_DATA_W = 8;
    localparam int unsigned N_CORES   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        LOAD,
        STORE
    } op_t;

endpackage

// File: rtl/sm_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   elig  - per-core eligibility vector
//   ptr   - index where the scan starts (highest priority this round)
//   valid - at least one core is eligible
//   idx   - first eligible core found scanning ptr, ptr+1, ... modulo N
module rr_pick #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = 4
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int unsigned  c;
    logic [IW-1:0] c_idx;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        c_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr is always < N, so a single conditional subtract wraps correctly
            c = 32'(ptr) + i;
            if (c >= N) begin
                c = c - N;
            end
            c_idx = IW'(c);
            if (!valid && elig[c_idx]) begin
                valid = 1'b1;
                idx   = c_idx;
            end
        end
    end

endmodule

// File: rtl/sm_arbiter.sv
// sm_arbiter: round-robin arbiter sharing one single-port SRAM between cores.
//   clk, reset   - clock, asynchronous active-high reset
//   mem_req_ld   - per-core level load request
//   mem_req_st   - per-core level store request
//   addr_in      - per-core address, core k at [k*ADDR_W +: ADDR_W]
//   wdata_in     - per-core store data, core k at [k*DATA_W +: DATA_W]
//   val_data     - one-hot one-cycle completion pulse to the served core
//   mem_dat      - load data, valid while val_data pulses for a load
//   sm_en/sm_we  - SRAM strobe / write enable
//   sm_addr      - SRAM address
//   sm_wdata     - SRAM write data
//   sm_rdata     - SRAM read data, valid RD_LAT cycles after the sm_en cycle
//   busy         - high whenever the FSM is not idle
//   grant_id     - index of the core currently or last served
module sm_arbiter
    import sm_pkg::*;
#(
    parameter int unsigned N_CORES = sm_pkg::N_CORES,
    parameter int unsigned ADDR_W  = sm_pkg::SM_ADDR_W,
    parameter int unsigned DATA_W  = sm_pkg::SM_DATA_W,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          mem_req_ld,
    input  logic [N_CORES-1:0]          mem_req_st,
    input  logic [N_CORES*ADDR_W-1:0]   addr_in,
    input  logic [N_CORES*DATA_W-1:0]   wdata_in,
    output logic [N_CORES-1:0]          val_data,
    output logic [DATA_W-1:0]           mem_dat,
    output logic                        sm_en,
    output logic                        sm_we,
    output logic [ADDR_W-1:0]           sm_addr,
    output logic [DATA_W-1:0]           sm_wdata,
    input  logic [DATA_W-1:0]           sm_rdata,
    output logic                        busy,
    output logic [$clog2(N_CORES)-1:0]  grant_id
);

    localparam int unsigned IW = $clog2(N_CORES);

    state_t             state;
    op_t                op;
    logic [N_CORES-1:0] done;
    logic [N_CORES-1:0] req_any;
    logic [N_CORES-1:0] elig;
    logic [IW-1:0]      rr_ptr;
    logic [2:0]         cnt;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;

    always_comb begin
        req_any = mem_req_ld | mem_req_st;
        elig    = req_any & ~done;
    end

    rr_pick #(
        .N  (N_CORES),
        .IW (IW)
    ) u_rr_pick (
        .elig  (elig),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op       <= LOAD;
            done     <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            val_data <= '0;
            mem_dat  <= '0;
            sm_en    <= 1'b0;
            sm_we    <= 1'b0;
            sm_addr  <= '0;
            sm_wdata <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            // A done flag survives only while its core keeps requesting;
            // the RESP branch below sets the served core's bit afterwards.
            done     <= done & req_any;
            val_data <= '0;
            sm_en    <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        // load wins when both request bits are high
                        op       <= mem_req_ld[pick_idx] ? LOAD : STORE;
                        sm_addr  <= addr_in[pick_idx*ADDR_W +: ADDR_W];
                        sm_wdata <= wdata_in[pick_idx*DATA_W +: DATA_W];
                        sm_en    <= 1'b1;
                        sm_we    <= ~mem_req_ld[pick_idx];
                        busy     <= 1'b1;
                        rr_ptr   <= (pick_idx == IW'(N_CORES - 1)) ? '0 : pick_idx + 1'b1;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    sm_we <= 1'b0;
                    if (op == LOAD) begin
                        cnt   <= 3'(RD_LAT - 1);
                        state <= WAIT;
                    end else begin
                        val_data[grant_id] <= 1'b1;
                        state              <= RESP;
                    end
                end

                WAIT: begin
                    if (cnt == 3'd0) begin
                        mem_dat            <= sm_rdata;
                        val_data[grant_id] <= 1'b1;
                        state              <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end

                RESP: begin
                    done[grant_id] <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_arbiter.sv
// tb_sm_arbiter: directed self-checking bench for sm_arbiter.
//   u_dut1 runs with RD_LAT=1, u_dut3 with RD_LAT=3; both share the request
//   inputs and each has its own behavioural SRAM model.
module tb_sm_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic init_mem;

    logic [15:0]     ld;
    logic [15:0]     st;
    logic [16*12-1:0] addr_in;
    logic [16*8-1:0]  wdata_in;

    logic [15:0] val1, val3;
    logic [7:0]  mem_dat1, mem_dat3;
    logic        sm_en1, sm_en3, sm_we1, sm_we3;
    logic [11:0] sm_addr1, sm_addr3;
    logic [7:0]  sm_wdata1, sm_wdata3;
    logic [7:0]  rdata1, rdata3;
    logic        busy1, busy3;
    logic [3:0]  gid1, gid3;

    logic [7:0] mem1 [0:4095];
    logic [7:0] mem3 [0:4095];
    logic [7:0] p3   [0:2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm_arbiter #(.N_CORES(16), .ADDR_W(12), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_req_ld(ld), .mem_req_st(st),
        .addr_in(addr_in), .wdata_in(wdata_in), .val_data(val1), .mem_dat(mem_dat1),
        .sm_en(sm_en1), .sm_we(sm_we1), .sm_addr(sm_addr1), .sm_wdata(sm_wdata1),
        .sm_rdata(rdata1), .busy(busy1), .grant_id(gid1)
    );

    sm_arbiter #(.N_CORES(16), .ADDR_W(12), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_req_ld(ld), .mem_req_st(st),
        .addr_in(addr_in), .wdata_in(wdata_in), .val_data(val3), .mem_dat(mem_dat3),
        .sm_en(sm_en3), .sm_we(sm_we3), .sm_addr(sm_addr3), .sm_wdata(sm_wdata3),
        .sm_rdata(rdata3), .busy(busy3), .grant_id(gid3)
    );

    // SRAM models: default content is addr[7:0] ^ 0x3C
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) begin
                mem1[i] <= 8'(i) ^ 8'h3C;
                mem3[i] <= 8'(i) ^ 8'h3C;
            end
        end else begin
            if (sm_en1) begin
                if (sm_we1) mem1[sm_addr1] <= sm_wdata1;
                rdata1 <= mem1[sm_addr1];
            end
            p3[1] <= p3[0];
            p3[2] <= p3[1];
            if (sm_en3) begin
                if (sm_we3) mem3[sm_addr3] <= sm_wdata3;
                p3[0] <= mem3[sm_addr3];
            end
        end
    end
    assign rdata3 = p3[2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int k, input logic [11:0] a, input logic [7:0] d);
        addr_in[k*12 +: 12] = a;
        wdata_in[k*8 +: 8]  = d;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ld    = '0;
        st    = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        init_mem = 1'b1;
        ld       = '0;
        st       = '0;
        addr_in  = '0;
        wdata_in = '0;
        tick();
        init_mem = 1'b0;
        tick();

        // reset state
        chk("rst_val",   32'(val1), 0);
        chk("rst_mdat",  32'(mem_dat1), 0);
        chk("rst_en",    32'(sm_en1), 0);
        chk("rst_we",    32'(sm_we1), 0);
        chk("rst_addr",  32'(sm_addr1), 0);
        chk("rst_wdata", 32'(sm_wdata1), 0);
        chk("rst_busy",  32'(busy1), 0);
        chk("rst_gid",   32'(gid1), 0);
        reset = 1'b0;

        // single store by core 3, then load back
        set_core(3, 12'h123, 8'h5A);
        st[3] = 1'b1;
        chk("st_c0_busy", 32'(busy1), 0);
        tick();
        chk("st_c1_en",    32'(sm_en1), 1);
        chk("st_c1_we",    32'(sm_we1), 1);
        chk("st_c1_addr",  32'(sm_addr1), 32'h123);
        chk("st_c1_wdata", 32'(sm_wdata1), 32'h5A);
        chk("st_c1_gid",   32'(gid1), 3);
        chk("st_c1_busy",  32'(busy1), 1);
        tick();
        chk("st_c2_val", 32'(val1), 32'h0008);
        chk("st_c2_en",  32'(sm_en1), 0);
        st[3] = 1'b0;
        tick();
        chk("st_c3_val",  32'(val1), 0);
        chk("st_c3_busy", 32'(busy1), 0);
        tick();
        ld[3] = 1'b1;
        tick();
        chk("ld_c1_en",   32'(sm_en1), 1);
        chk("ld_c1_we",   32'(sm_we1), 0);
        chk("ld_c1_addr", 32'(sm_addr1), 32'h123);
        tick();
        chk("ld_c2_val",  32'(val1), 0);
        chk("ld_c2_busy", 32'(busy1), 1);
        tick();
        chk("ld_c3_val",  32'(val1), 32'h0008);
        chk("ld_c3_mdat", 32'(mem_dat1), 32'h5A);
        ld[3] = 1'b0;
        tick();
        chk("ld_c4_val", 32'(val1), 0);

        // all 16 cores load at once: grants 0..15, 4 cycles apart
        do_reset();
        for (int k = 0; k < 16; k++) set_core(k, 12'h100 + 12'(k), 8'h00);
        ld = 16'hFFFF;
        for (int g = 0; g < 16; g++) begin
            tick();
            chk("rr_en",  32'(sm_en1), 1);
            chk("rr_gid", 32'(gid1), 32'(g));
            tick();
            chk("rr_en_low", 32'(sm_en1), 0);
            tick();
            chk("rr_val",  32'(val1), 32'(16'h0001 << g));
            chk("rr_mdat", 32'(mem_dat1), 32'(8'(g) ^ 8'h3C));
            tick();
            ld[g] = 1'b0;
        end
        chk("rr_end_busy", 32'(busy1), 0);

        // core 5 holds its store; core 9 is served next; 5 again only after a drop
        do_reset();
        set_core(5, 12'h055, 8'h11);
        set_core(9, 12'h099, 8'h22);
        st[5] = 1'b1;
        st[9] = 1'b1;
        tick();
        chk("hold_g5",    32'(gid1), 5);
        chk("hold_en5",   32'(sm_en1), 1);
        tick();
        chk("hold_val5",  32'(val1), 32'h0020);
        tick();
        chk("hold_idle",  32'(busy1), 0);
        tick();
        chk("hold_g9",    32'(gid1), 9);
        chk("hold_en9",   32'(sm_en1), 1);
        tick();
        chk("hold_val9",  32'(val1), 32'h0200);
        st[9] = 1'b0;
        tick();
        tick();
        chk("hold_noreserve_en",   32'(sm_en1), 0);
        chk("hold_noreserve_busy", 32'(busy1), 0);
        tick();
        chk("hold_noreserve_busy2", 32'(busy1), 0);
        st[5] = 1'b0;
        tick();
        st[5] = 1'b1;
        tick();
        chk("hold_reg5", 32'(gid1), 5);
        chk("hold_ren5", 32'(sm_en1), 1);
        tick();
        chk("hold_rval5", 32'(val1), 32'h0020);
        st[5] = 1'b0;

        // ld+st together on core 0; RD_LAT=3 instance
        do_reset();
        set_core(0, 12'h0FF, 8'hEE);
        ld[0] = 1'b1;
        st[0] = 1'b1;
        tick();
        chk("ldst3_en",   32'(sm_en3), 1);
        chk("ldst3_we",   32'(sm_we3), 0);
        chk("ldst3_addr", 32'(sm_addr3), 32'h0FF);
        chk("ldst1_we",   32'(sm_we1), 0);
        tick();
        tick();
        chk("ldst1_val",  32'(val1), 32'h0001);
        chk("ldst1_mdat", 32'(mem_dat1), 32'hC3);
        chk("ldst3_c3_val", 32'(val3), 0);
        tick();
        chk("ldst3_c4_val",  32'(val3), 0);
        chk("ldst3_c4_busy", 32'(busy3), 1);
        tick();
        chk("ldst3_c5_val",  32'(val3), 32'h0001);
        chk("ldst3_c5_mdat", 32'(mem_dat3), 32'hC3);
        ld[0] = 1'b0;
        st[0] = 1'b0;
        tick();
        chk("ldst3_c6_val",  32'(val3), 0);
        chk("ldst3_c6_busy", 32'(busy3), 0);

        // reset asserted in WAIT during a core 7 load
        do_reset();
        set_core(7, 12'h077, 8'h00);
        set_core(9, 12'h099, 8'h00);
        ld[7] = 1'b1;
        tick();
        chk("mr_en", 32'(sm_en1), 1);
        chk("mr_gid", 32'(gid1), 7);
        tick();
        chk("mr_wait_busy", 32'(busy1), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_busy",  32'(busy1), 0);
        chk("mr_en0",   32'(sm_en1), 0);
        chk("mr_gid0",  32'(gid1), 0);
        chk("mr_addr0", 32'(sm_addr1), 0);
        chk("mr_val0",  32'(val1), 0);
        chk("mr_busy3", 32'(busy3), 0);
        tick();
        chk("mr_val_held", 32'(val1), 0);
        reset = 1'b0;
        ld[9] = 1'b1;
        tick();
        chk("mr_post_gid", 32'(gid1), 7);
        chk("mr_post_en",  32'(sm_en1), 1);
        tick();
        chk("mr_post_wait_val", 32'(val1), 0);
        tick();
        chk("mr_post_val",  32'(val1), 32'h0080);
        chk("mr_post_mdat", 32'(mem_dat1), 32'h4B);
        ld = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
